rs_decode_seq: RTL and testbench

RS_DECODE_SEQ -- requirements
Module: rs_decode_seq

---
 rtl/rs_decode_seq.sv | 197 +++++++++++++++++++
 tb/tb_rs_decode_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_decode_seq.sv
`default_nettype none
// ============================================================================
// Module      : rs_decode_seq
// Description : Sequencer around a Reed-Solomon decoder core. Streams a
//               codeword buffer into the core, collects the error-position
//               result stream into a second buffer, and reports status
//               flags, timeout, protocol errors and a completion interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_decode_seq #(
    parameter  int NUM_WORDS = 50,
    parameter  int WORD_W    = 32,
    parameter  int TMO_W     = 16,
    localparam int IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic [TMO_W-1:0]  tmo_i,
    output logic              core_in_valid_o,
    output logic [WORD_W-1:0] core_in_data_o,
    output logic              core_in_last_o,
    input  logic              core_in_ready_i,
    input  logic              core_out_valid_i,
    input  logic [WORD_W-1:0] core_out_data_i,
    input  logic              core_out_last_i,
    input  logic              core_out_err_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [WORD_W-1:0] rd_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              with_error_o,
    output logic              tmo_o,
    output logic              proto_err_o,
    output logic              irq_o
);

    localparam logic [IDX_W:0]   C_NUM_WORDS = (IDX_W+1)'(NUM_WORDS);
    localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_COLLECT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_send_idx;
    logic [IDX_W:0]     r_col_idx;     // one extra bit so it can hold NUM_WORDS
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_done;
    logic               r_with_error;
    logic               r_tmo;
    logic               r_proto_err;
    logic               r_irq;
    logic [WORD_W-1:0]  r_rd_data;
    logic [WORD_W-1:0]  r_cw_buf [NUM_WORDS];
    logic [WORD_W-1:0]  r_ep_buf [NUM_WORDS];

    logic               w_busy;
    logic [TMO_W-1:0]   w_tmo_next;
    logic               w_wr_in_range;
    logic               w_rd_in_range;

    assign w_busy        = (r_state == S_SEND) || (r_state == S_COLLECT);
    assign w_tmo_next    = r_tmo_cnt + TMO_W'(1);
    assign w_wr_in_range = ({1'b0, wr_idx_i} < C_NUM_WORDS);
    assign w_rd_in_range = ({1'b0, rd_idx_i} < C_NUM_WORDS);

    // Sequencer FSM: send, collect, timeout, sticky flags and result buffer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_send_idx   <= '0;
            r_col_idx    <= '0;
            r_tmo_cnt    <= '0;
            r_done       <= 1'b0;
            r_with_error <= 1'b0;
            r_tmo        <= 1'b0;
            r_proto_err  <= 1'b0;
            r_irq        <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) r_ep_buf[i] <= '0;
        end else begin
            r_irq <= 1'b0;
            if (clear_i) begin
                // Abort wins over any other request in the same cycle
                r_state      <= S_IDLE;
                r_send_idx   <= '0;
                r_col_idx    <= '0;
                r_tmo_cnt    <= '0;
                r_done       <= 1'b0;
                r_with_error <= 1'b0;
                r_tmo        <= 1'b0;
                r_proto_err  <= 1'b0;
                for (int i = 0; i < NUM_WORDS; i++) r_ep_buf[i] <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            r_state      <= S_SEND;
                            r_send_idx   <= '0;
                            r_col_idx    <= '0;
                            r_tmo_cnt    <= '0;
                            r_done       <= 1'b0;
                            r_with_error <= 1'b0;
                            r_tmo        <= 1'b0;
                            r_proto_err  <= 1'b0;
                            for (int i = 0; i < NUM_WORDS; i++) r_ep_buf[i] <= '0;
                        end
                    end
                    S_SEND: begin
                        if (core_in_ready_i) begin
                            if (r_send_idx == C_LAST_IDX) begin
                                r_state   <= S_COLLECT;
                                r_tmo_cnt <= '0;
                                r_col_idx <= '0;
                            end else begin
                                r_send_idx <= r_send_idx + IDX_W'(1);
                            end
                        end
                    end
                    S_COLLECT: begin
                        if (core_out_valid_i) begin
                            r_tmo_cnt <= '0;
                            if (r_col_idx < C_NUM_WORDS) begin
                                r_ep_buf[r_col_idx[IDX_W-1:0]] <= core_out_data_i;
                                r_col_idx <= r_col_idx + (IDX_W+1)'(1);
                            end else begin
                                r_proto_err <= 1'b1;
                            end
                            if (core_out_err_i) r_with_error <= 1'b1;
                            if (core_out_last_i) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_irq   <= 1'b1;
                            end
                        end else begin
                            r_tmo_cnt <= w_tmo_next;
                            if ((tmo_i != '0) && (w_tmo_next == tmo_i)) begin
                                r_state <= S_DONE;
                                r_tmo   <= 1'b1;
                                r_done  <= 1'b1;
                                r_irq   <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
                // Protocol violations are recorded after the state update so a
                // violation in the same cycle as start is not lost
                if (wr_en_i && w_busy) r_proto_err <= 1'b1;
                if (core_out_valid_i && (r_state != S_COLLECT)) r_proto_err <= 1'b1;
            end
        end
    end

    // Codeword buffer: host writes only while idle, clear leaves contents intact
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_WORDS; i++) r_cw_buf[i] <= '0;
        end else if (wr_en_i && !clear_i && (r_state == S_IDLE) && w_wr_in_range) begin
            r_cw_buf[wr_idx_i] <= wr_data_i;
        end
    end

    // Registered error-position readback, zero for indices past the buffer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_in_range ? r_ep_buf[rd_idx_i] : '0;
        end
    end

    assign core_in_valid_o = (r_state == S_SEND);
    assign core_in_data_o  = (r_state == S_SEND) ? r_cw_buf[r_send_idx] : '0;
    assign core_in_last_o  = (r_state == S_SEND) && (r_send_idx == C_LAST_IDX);
    assign rd_data_o       = r_rd_data;
    assign busy_o          = w_busy;
    assign done_o          = r_done;
    assign with_error_o    = r_with_error;
    assign tmo_o           = r_tmo;
    assign proto_err_o     = r_proto_err;
    assign irq_o           = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_rs_decode_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_decode_seq
// Description : Directed self-checking bench for rs_decode_seq. Readback
//               expectations come from per-scenario vector tables; the send
//               stream is checked against a bench-side codeword model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_decode_seq;

    localparam int NW = 50;
    localparam int WW = 32;
    localparam int TW = 16;
    localparam int IW = 6;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [WW-1:0] wr_data;
    logic          start;
    logic          clear;
    logic [TW-1:0] tmo;
    logic          core_in_valid;
    logic [WW-1:0] core_in_data;
    logic          core_in_last;
    logic          core_in_ready;
    logic          core_out_valid;
    logic [WW-1:0] core_out_data;
    logic          core_out_last;
    logic          core_out_err;
    logic [IW-1:0] rd_idx;
    logic [WW-1:0] rd_data;
    logic          busy, done, with_error, tmo_flag, proto_err, irq;

    rs_decode_seq #(.NUM_WORDS(NW), .WORD_W(WW), .TMO_W(TW)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .wr_en_i          (wr_en),
        .wr_idx_i         (wr_idx),
        .wr_data_i        (wr_data),
        .start_i          (start),
        .clear_i          (clear),
        .tmo_i            (tmo),
        .core_in_valid_o  (core_in_valid),
        .core_in_data_o   (core_in_data),
        .core_in_last_o   (core_in_last),
        .core_in_ready_i  (core_in_ready),
        .core_out_valid_i (core_out_valid),
        .core_out_data_i  (core_out_data),
        .core_out_last_i  (core_out_last),
        .core_out_err_i   (core_out_err),
        .rd_idx_i         (rd_idx),
        .rd_data_o        (rd_data),
        .busy_o           (busy),
        .done_o           (done),
        .with_error_o     (with_error),
        .tmo_o            (tmo_flag),
        .proto_err_o      (proto_err),
        .irq_o            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int irq_cnt  = 0;
    logic [WW-1:0] cw_model [NW];

    typedef struct {
        int            idx;
        logic [WW-1:0] exp;
    } rd_vec_t;

    rd_vec_t tab_basic [9];
    rd_vec_t tab_ovf   [6];

    // Count irq pulses seen at the sampling edge
    always @(negedge clk) if (irq === 1'b1) irq_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic write_word(input int idx, input logic [WW-1:0] data);
        wr_en   = 1'b1;
        wr_idx  = IW'(idx);
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic rd_check(input int idx, input logic [WW-1:0] exp);
        rd_idx = IW'(idx);
        @(negedge clk);
        check($sformatf("rd_data[%0d]", idx), 64'(rd_data), 64'(exp));
    endtask

    task automatic out_beat(input logic [WW-1:0] data, input bit last, input bit err);
        core_out_valid = 1'b1;
        core_out_data  = data;
        core_out_last  = last;
        core_out_err   = err;
        @(negedge clk);
        core_out_valid = 1'b0;
        core_out_last  = 1'b0;
        core_out_err   = 1'b0;
    endtask

    // Caller raises start one cycle before; returns just after COLLECT entry
    task automatic send_stream(input bit toggle, input bit zero_exp,
                               output int cycles, output int bad);
        int k;
        logic [WW-1:0] exp;
        k = 0;
        cycles = 0;
        bad = 0;
        @(negedge clk);
        start = 1'b0;
        while (k < NW && cycles < 1000) begin
            if (core_in_valid !== 1'b1) begin
                bad++;
                break;
            end
            core_in_ready = toggle ? (cycles % 2 == 1) : 1'b1;
            if (core_in_last !== (k == NW - 1)) bad++;
            if (core_in_ready) begin
                exp = zero_exp ? '0 : cw_model[k];
                if (core_in_data !== exp) bad++;
                k++;
            end
            cycles++;
            @(negedge clk);
        end
        core_in_ready = 1'b0;
    endtask

    initial begin
        int cyc, bad, c;

        tab_basic[0] = '{0,  32'h100};
        tab_basic[1] = '{5,  32'h105};
        tab_basic[2] = '{9,  32'h109};
        tab_basic[3] = '{10, 32'h0};
        tab_basic[4] = '{11, 32'h0};
        tab_basic[5] = '{30, 32'h0};
        tab_basic[6] = '{49, 32'h0};
        tab_basic[7] = '{50, 32'h0};
        tab_basic[8] = '{63, 32'h0};

        tab_ovf[0] = '{0,  32'h200};
        tab_ovf[1] = '{5,  32'h205};
        tab_ovf[2] = '{25, 32'h219};
        tab_ovf[3] = '{49, 32'h231};
        tab_ovf[4] = '{50, 32'h0};
        tab_ovf[5] = '{63, 32'h0};

        rst = 1'b1;
        wr_en = 1'b0; wr_idx = '0; wr_data = '0;
        start = 1'b0; clear = 1'b0; tmo = '0;
        core_in_ready = 1'b0;
        core_out_valid = 1'b0; core_out_data = '0; core_out_last = 1'b0; core_out_err = 1'b0;
        rd_idx = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_status", 64'({busy, done, with_error, tmo_flag, proto_err, irq}), 64'd0);
        check("reset_core_in", 64'({core_in_valid, core_in_last, core_in_data}), 64'd0);
        check("reset_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic run: load idx+1, constant ready, 10 result beats
        for (int i = 0; i < NW; i++) begin
            cw_model[i] = WW'(i + 1);
            write_word(i, cw_model[i]);
        end
        irq_cnt = 0;
        start = 1'b1;
        send_stream(1'b0, 1'b0, cyc, bad);
        check("basic_send_cycles", 64'(cyc), 64'd50);
        check("basic_send_data_errs", 64'(bad), 64'd0);
        check("basic_collect_busy", 64'({busy, core_in_valid}), 64'b10);
        for (int i = 0; i < 10; i++) out_beat(WW'(32'h100 + i), (i == 9), 1'b0);
        check("basic_done_irq", 64'({done, irq, busy}), 64'b110);
        @(negedge clk);
        check("basic_irq_one_cycle", 64'({irq, busy}), 64'b00);
        repeat (3) @(negedge clk);
        check("basic_irq_count", 64'(irq_cnt), 64'd1);
        check("basic_flags", 64'({done, with_error, tmo_flag, proto_err}), 64'b1000);
        for (int i = 0; i < 9; i++) rd_check(tab_basic[i].idx, tab_basic[i].exp);

        // Result beat while idle is a protocol error; done stays sticky
        out_beat(32'h77, 1'b0, 1'b0);
        check("idle_beat_proto", 64'({proto_err, done}), 64'b11);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_flags", 64'({done, with_error, tmo_flag, proto_err}), 64'd0);

        // Ready toggling halves throughput
        start = 1'b1;
        send_stream(1'b1, 1'b0, cyc, bad);
        check("toggle_send_cycles", 64'(cyc), 64'd100);
        check("toggle_send_data_errs", 64'(bad), 64'd0);
        out_beat(32'h1, 1'b1, 1'b0);
        @(negedge clk);

        // Timeout of 20 cycles with silent core
        tmo = 16'd20;
        start = 1'b1;
        send_stream(1'b0, 1'b0, cyc, bad);
        c = 0;
        while (done !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("tmo_latency", 64'(c), 64'd20);
        check("tmo_flags", 64'({tmo_flag, done, busy}), 64'b110);
        @(negedge clk);

        // Timeout disabled: stays collecting, then clear with start aborts
        tmo = '0;
        start = 1'b1;
        send_stream(1'b0, 1'b0, cyc, bad);
        irq_cnt = 0;
        repeat (200) @(negedge clk);
        check("no_tmo_still_busy", 64'({busy, done, tmo_flag}), 64'b100);
        out_beat(32'h55, 1'b0, 1'b1);
        check("err_beat_with_error", 64'(with_error), 64'd1);
        clear = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        check("clear_abort_flags", 64'({busy, done, with_error, tmo_flag, proto_err}), 64'd0);
        @(negedge clk);
        check("clear_abort_idle", 64'({busy, irq_cnt[3:0]}), 64'd0);
        rd_check(0, 32'h0);
        start = 1'b1;
        send_stream(1'b0, 1'b0, cyc, bad);
        check("resend_unchanged_errs", 64'(bad), 64'd0);

        // Overflow: 60 beats without last, one carrying err
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b1;
        send_stream(1'b0, 1'b0, cyc, bad);
        for (int i = 0; i < 60; i++) begin
            out_beat(WW'(32'h200 + i), 1'b0, (i == 5));
            if (i == 49) check("ovf_proto_at_50", 64'(proto_err), 64'd0);
        end
        check("ovf_flags", 64'({proto_err, with_error, busy}), 64'b111);
        out_beat(32'h999, 1'b1, 1'b0);
        check("ovf_done", 64'(done), 64'd1);
        for (int i = 0; i < 6; i++) rd_check(tab_ovf[i].idx, tab_ovf[i].exp);

        // Write while busy is dropped and flagged
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        write_word(3, 32'hDEAD);
        check("busy_write_proto", 64'(proto_err), 64'd1);
        send_stream(1'b0, 1'b0, cyc, bad);
        check("busy_write_dropped_errs", 64'(bad), 64'd0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        write_word(55, 32'hBAD);
        check("oor_write_silent", 64'(proto_err), 64'd0);

        // Reset mid-SEND clears everything including the codeword buffer
        irq_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        core_in_ready = 1'b1;
        repeat (5) @(negedge clk);
        core_in_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_send_status", 64'({busy, done, with_error, tmo_flag, proto_err, irq}), 64'd0);
        check("rst_mid_send_core_in", 64'({core_in_valid, core_in_last, core_in_data}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1;
        send_stream(1'b0, 1'b1, cyc, bad);
        check("rst_buffer_zero_errs", 64'(bad), 64'd0);
        check("rst_no_irq", 64'(irq_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
